fwd_hazard_unit: RTL and testbench

Parametrised operand-bypass and load-use hazard unit for the in-order RISC-V pipeline. It compares ID-stage source registers against the destinations in flight and registers per-source bypass selects into EX. It holds the last write-back value so the register file needs no write-through. It also drives the operand muxes and a counted load-use stall.

---
 rtl/fwd_hazard_unit_if.sv | 38 +++
 rtl/fwd_hazard_unit.sv | 121 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the pipeline control and fwd_hazard_unit: ID/EX/MEM/WB compare
// inputs and operand data in, stall, registered bypass selects and EX operands out.
interface fwd_hazard_unit_if #(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
) ();
    logic                      flush;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_regwrite;
    logic                      ex_memread;
    logic [REG_AW-1:0]         ex_mem_rd;
    logic                      ex_mem_regwrite;
    logic [DATA_W-1:0]         ex_mem_data;
    logic [REG_AW-1:0]         mem_wb_rd;
    logic                      mem_wb_regwrite;
    logic [DATA_W-1:0]         mem_wb_data;
    logic [NUM_SRC*DATA_W-1:0] ex_rf_data;
    logic                      stall;
    logic [NUM_SRC*2-1:0]      ex_fwd_sel;
    logic [NUM_SRC*DATA_W-1:0] ex_op;

    modport master (
        output flush, id_rs, id_rs_used, ex_rd, ex_regwrite, ex_memread,
               ex_mem_rd, ex_mem_regwrite, ex_mem_data,
               mem_wb_rd, mem_wb_regwrite, mem_wb_data, ex_rf_data,
        input  stall, ex_fwd_sel, ex_op
    );

    modport slave (
        input  flush, id_rs, id_rs_used, ex_rd, ex_regwrite, ex_memread,
               ex_mem_rd, ex_mem_regwrite, ex_mem_data,
               mem_wb_rd, mem_wb_regwrite, mem_wb_data, ex_rf_data,
        output stall, ex_fwd_sel, ex_op
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand bypass select / mux and load-use stall sequencer for the in-order pipeline.
// Selects are computed in ID and registered into EX; the WB value is held for one RF-stale read.
module fwd_hazard_unit #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave bus
);
    localparam int               CNT_W    = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t                    state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [NUM_SRC*2-1:0]      id_sel;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [NUM_SRC-1:0]        src_hazard;
    logic                      hazard;
    logic                      stall;
    logic [DATA_W-1:0]         hold_data;
    logic [NUM_SRC*DATA_W-1:0] op;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_AW-1:0] rs;
        logic              live;
        logic              m_ex, m_mem, m_wb;
        logic [1:0]        sel_q;

        assign rs    = bus.id_rs[g*REG_AW +: REG_AW];
        assign live  = bus.id_rs_used[g] && (rs != '0);
        assign m_ex  = live && bus.ex_regwrite     && (bus.ex_rd     == rs);
        assign m_mem = live && bus.ex_mem_regwrite && (bus.ex_mem_rd == rs);
        assign m_wb  = live && bus.mem_wb_regwrite && (bus.mem_wb_rd == rs);

        assign src_hazard[g] = m_ex && bus.ex_memread;

        // Youngest producer wins; a load in EX cannot bypass and is handled by the stall.
        assign id_sel[g*2 +: 2] = (m_ex && !bus.ex_memread) ? 2'b11 :
                                  m_mem                      ? 2'b10 :
                                  m_wb                       ? 2'b01 : 2'b00;

        assign sel_q = fwd_sel[g*2 +: 2];
        assign op[g*DATA_W +: DATA_W] = (sel_q == 2'b11) ? bus.ex_mem_data :
                                        (sel_q == 2'b10) ? bus.mem_wb_data :
                                        (sel_q == 2'b01) ? hold_data       :
                                                           bus.ex_rf_data[g*DATA_W +: DATA_W];
    end

    assign hazard = |src_hazard;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        if (bus.flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hazard) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_next = STALL;
                            cnt_next   = CNT_LOAD;
                        end
                    end
                end
                STALL: begin
                    stall    = 1'b1;
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            fwd_sel <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (bus.flush || stall) begin
                fwd_sel <= '0;
            end else begin
                fwd_sel <= id_sel;
            end
        end
    end

    // NOTE: hold_data is a single data register, so it is reset like control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
        end else if (bus.mem_wb_regwrite) begin
            hold_data <= bus.mem_wb_data;
        end
    end

    // The Mealy IDLE path would otherwise see live compares while reset is held.
    assign bus.stall      = stall && rst_n;
    assign bus.ex_fwd_sel = fwd_sel;
    assign bus.ex_op      = op;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Drives one stimulus stream into LOAD_LAT=1 and LOAD_LAT=3 instances and checks
// both against a cycle-level reference model of the bypass and stall rules.
module tb_fwd_hazard_unit;
    localparam int DW  = 8;
    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int RFW = NS * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           flush;
    logic [NS*AW-1:0] id_rs;
    logic [NS-1:0]  id_rs_used;
    logic [AW-1:0]  ex_rd, ex_mem_rd, mem_wb_rd;
    logic           ex_regwrite, ex_memread, ex_mem_regwrite, mem_wb_regwrite;
    logic [DW-1:0]  ex_mem_data, mem_wb_data;
    logic [RFW-1:0] ex_rf_data;

    fwd_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) bus1 ();
    fwd_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) bus3 ();

    assign bus1.flush = flush;             assign bus3.flush = flush;
    assign bus1.id_rs = id_rs;             assign bus3.id_rs = id_rs;
    assign bus1.id_rs_used = id_rs_used;   assign bus3.id_rs_used = id_rs_used;
    assign bus1.ex_rd = ex_rd;             assign bus3.ex_rd = ex_rd;
    assign bus1.ex_regwrite = ex_regwrite; assign bus3.ex_regwrite = ex_regwrite;
    assign bus1.ex_memread = ex_memread;   assign bus3.ex_memread = ex_memread;
    assign bus1.ex_mem_rd = ex_mem_rd;     assign bus3.ex_mem_rd = ex_mem_rd;
    assign bus1.ex_mem_regwrite = ex_mem_regwrite; assign bus3.ex_mem_regwrite = ex_mem_regwrite;
    assign bus1.ex_mem_data = ex_mem_data; assign bus3.ex_mem_data = ex_mem_data;
    assign bus1.mem_wb_rd = mem_wb_rd;     assign bus3.mem_wb_rd = mem_wb_rd;
    assign bus1.mem_wb_regwrite = mem_wb_regwrite; assign bus3.mem_wb_regwrite = mem_wb_regwrite;
    assign bus1.mem_wb_data = mem_wb_data; assign bus3.mem_wb_data = mem_wb_data;
    assign bus1.ex_rf_data = ex_rf_data;   assign bus3.ex_rf_data = ex_rf_data;

    fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int checks = 0;
    int failures = 0;

    // Reference model: remaining bubbles, EX selects, and last written-back value.
    int            lat [2] = '{1, 3};
    int            left [2];
    logic [1:0]    msel [2][NS];
    logic [DW-1:0] mhold;

    function automatic logic dut_stall(int m);
        return (m == 0) ? bus1.stall : bus3.stall;
    endfunction

    function automatic logic [1:0] dut_sel(int m, int i);
        return (m == 0) ? bus1.ex_fwd_sel[i*2 +: 2] : bus3.ex_fwd_sel[i*2 +: 2];
    endfunction

    function automatic logic [DW-1:0] dut_op(int m, int i);
        return (m == 0) ? bus1.ex_op[i*DW +: DW] : bus3.ex_op[i*DW +: DW];
    endfunction

    function automatic logic [1:0] ref_sel(int i);
        logic [AW-1:0] r;
        logic          live;
        r    = id_rs[i*AW +: AW];
        live = id_rs_used[i] && (r != 0);
        if (live && ex_regwrite && ex_rd == r && !ex_memread) return 2'b11;
        if (live && ex_mem_regwrite && ex_mem_rd == r)        return 2'b10;
        if (live && mem_wb_regwrite && mem_wb_rd == r)        return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_hazard();
        logic h = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (id_rs_used[i] && id_rs[i*AW +: AW] != 0 && ex_regwrite && ex_memread &&
                ex_rd == id_rs[i*AW +: AW])
                h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [DW-1:0] ref_op(logic [1:0] s, int i);
        case (s)
            2'b11:   return ex_mem_data;
            2'b10:   return mem_wb_data;
            2'b01:   return mhold;
            default: return ex_rf_data[i*DW +: DW];
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            left[m] = 0;
            for (int i = 0; i < NS; i++) msel[m][i] = 2'b00;
        end
        mhold = '0;
    endtask

    task automatic clear_inputs();
        flush = 0; id_rs = '0; id_rs_used = '0;
        ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
        ex_mem_rd = '0; ex_mem_regwrite = 0; ex_mem_data = '0;
        mem_wb_rd = '0; mem_wb_regwrite = 0; mem_wb_data = '0;
        ex_rf_data = RFW'($urandom);
    endtask

    task automatic set_src(int i, int r);
        id_rs[i*AW +: AW] = AW'(r);
        id_rs_used[i] = 1'b1;
    endtask

    // One clock: compare both DUTs against the model at negedge, then advance the model.
    task automatic step();
        logic es [2];
        logic [1:0] ns [NS];
        @(negedge clk);
        for (int i = 0; i < NS; i++) ns[i] = ref_sel(i);
        for (int m = 0; m < 2; m++) begin
            es[m] = !flush && (left[m] > 0 || ref_hazard());
            checks++;
            if (dut_stall(m) !== es[m]) begin
                failures++;
                $display("FAIL stall lat=%0d t=%0t got=%b exp=%b", lat[m], $time, dut_stall(m), es[m]);
            end
            for (int i = 0; i < NS; i++) begin
                checks++;
                if (dut_sel(m, i) !== msel[m][i]) begin
                    failures++;
                    $display("FAIL sel%0d lat=%0d t=%0t got=%b exp=%b", i, lat[m], $time, dut_sel(m, i), msel[m][i]);
                end
                checks++;
                if (dut_op(m, i) !== ref_op(msel[m][i], i)) begin
                    failures++;
                    $display("FAIL op%0d lat=%0d t=%0t got=%h exp=%h", i, lat[m], $time, dut_op(m, i), ref_op(msel[m][i], i));
                end
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (flush) begin
                left[m] = 0;
                for (int i = 0; i < NS; i++) msel[m][i] = 2'b00;
            end else if (es[m]) begin
                left[m] = (left[m] > 0) ? left[m] - 1 : lat[m] - 1;
                for (int i = 0; i < NS; i++) msel[m][i] = 2'b00;
            end else begin
                for (int i = 0; i < NS; i++) msel[m][i] = ns[i];
            end
        end
        if (mem_wb_regwrite) mhold = mem_wb_data;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        rst_n = 0;
        #12;
        checks++;
        if (bus1.stall !== 1'b0 || bus3.stall !== 1'b0 || bus1.ex_fwd_sel !== '0 || bus3.ex_fwd_sel !== '0) begin
            failures++;
            $display("FAIL reset_state got stall=%b/%b sel=%b/%b exp 0", bus1.stall, bus3.stall, bus1.ex_fwd_sel, bus3.ex_fwd_sel);
        end
        checks++;
        if (bus1.ex_op !== ex_rf_data || bus3.ex_op !== ex_rf_data) begin
            failures++;
            $display("FAIL reset_op got=%h/%h exp=%h", bus1.ex_op, bus3.ex_op, ex_rf_data);
        end
        @(posedge clk); #1;
        rst_n = 1;
        step();
    endtask

    task automatic test_alu_dep();
        clear_inputs();
        ex_rd = 3; ex_regwrite = 1; set_src(0, 3);
        step();
        clear_inputs();
        ex_mem_data = 8'h5A;
        #2;
        checks++;
        if (bus1.ex_fwd_sel[1:0] !== 2'b11 || bus1.ex_op[7:0] !== 8'h5A) begin
            failures++;
            $display("FAIL alu_dep got sel=%b op=%h exp sel=11 op=5a", bus1.ex_fwd_sel[1:0], bus1.ex_op[7:0]);
        end
        step();
    endtask

    task automatic test_stale_rf();
        clear_inputs();
        mem_wb_rd = 7; mem_wb_regwrite = 1; mem_wb_data = 8'hC3; set_src(1, 7);
        step();
        clear_inputs();
        mem_wb_data = 8'h00;
        #2;
        checks++;
        if (bus1.ex_fwd_sel[3:2] !== 2'b01 || bus1.ex_op[15:8] !== 8'hC3) begin
            failures++;
            $display("FAIL stale_rf got sel=%b op=%h exp sel=01 op=c3", bus1.ex_fwd_sel[3:2], bus1.ex_op[15:8]);
        end
        step();
    endtask

    task automatic test_load_use_lat1();
        clear_inputs();
        ex_rd = 4; ex_regwrite = 1; ex_memread = 1; set_src(0, 4);
        #2;
        checks++;
        if (bus1.stall !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=1", bus1.stall);
        end
        step();
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        ex_mem_rd = 4; ex_mem_regwrite = 1;
        #2;
        checks++;
        if (bus1.stall !== 1'b0 || bus1.ex_fwd_sel[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL load_use_bubble got stall=%b sel=%b exp stall=0 sel=00", bus1.stall, bus1.ex_fwd_sel[1:0]);
        end
        step();
        clear_inputs();
        mem_wb_rd = 4; mem_wb_regwrite = 1; mem_wb_data = 8'h11;
        #2;
        checks++;
        if (bus1.ex_fwd_sel[1:0] !== 2'b10 || bus1.ex_op[7:0] !== 8'h11) begin
            failures++;
            $display("FAIL load_use_fwd got sel=%b op=%h exp sel=10 op=11", bus1.ex_fwd_sel[1:0], bus1.ex_op[7:0]);
        end
        step();
        clear_inputs();
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_stall_len_lat3();
        logic [5:0] pat = '0;
        clear_inputs();
        ex_rd = 6; ex_regwrite = 1; ex_memread = 1; set_src(1, 6);
        for (int k = 0; k < 6; k++) begin
            #2;
            pat[k] = bus3.stall;
            step();
            ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        end
        checks++;
        if (pat !== 6'b000111) begin
            failures++;
            $display("FAIL stall_len3 got=%b exp=000111", pat);
        end
    endtask

    task automatic test_flush_lat3();
        clear_inputs();
        ex_rd = 6; ex_regwrite = 1; ex_memread = 1; set_src(0, 6);
        step();
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        flush = 1;
        #2;
        checks++;
        if (bus3.stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got=%b exp=0", bus3.stall);
        end
        step();
        clear_inputs();
        #2;
        checks++;
        if (bus3.stall !== 1'b0 || bus3.ex_fwd_sel !== '0) begin
            failures++;
            $display("FAIL flush_after got stall=%b sel=%b exp 0", bus3.stall, bus3.ex_fwd_sel);
        end
        step();
    endtask

    task automatic test_x0_unused();
        clear_inputs();
        ex_rd = 0; ex_regwrite = 1; set_src(0, 0);
        step();
        clear_inputs();
        ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
        id_rs[AW +: AW] = 5; id_rs_used = 2'b01;
        #2;
        checks++;
        if (bus1.ex_fwd_sel[1:0] !== 2'b00 || bus1.stall !== 1'b0 || bus3.stall !== 1'b0) begin
            failures++;
            $display("FAIL x0_unused got sel=%b stall=%b/%b exp sel=00 stall=0", bus1.ex_fwd_sel[1:0], bus1.stall, bus3.stall);
        end
        step();
        clear_inputs();
        #2;
        checks++;
        if (bus1.ex_fwd_sel !== '0) begin
            failures++;
            $display("FAIL unused_sel got=%b exp=0", bus1.ex_fwd_sel);
        end
        step();
    endtask

    task automatic test_priority();
        clear_inputs();
        ex_rd = 9; ex_mem_rd = 9; mem_wb_rd = 9;
        ex_regwrite = 1; ex_mem_regwrite = 1; mem_wb_regwrite = 1; set_src(0, 9);
        step();
        clear_inputs();
        #2;
        checks++;
        if (bus1.ex_fwd_sel[1:0] !== 2'b11 || bus3.ex_fwd_sel[1:0] !== 2'b11) begin
            failures++;
            $display("FAIL priority got=%b/%b exp=11", bus1.ex_fwd_sel[1:0], bus3.ex_fwd_sel[1:0]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        ex_rd = 2; ex_regwrite = 1; ex_memread = 1; set_src(1, 2);
        for (int k = 0; k < 7; k++) begin
            #2;
            checks++;
            if (bus1.stall !== 1'b1 || bus3.stall !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b/%b exp=1/1", k, bus1.stall, bus3.stall);
            end
            step();
        end
        clear_inputs();
        flush = 1;
        step();
        flush = 0;
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        ex_rd = 8; ex_regwrite = 1; ex_memread = 1; set_src(0, 8);
        step();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (bus1.stall !== 1'b0 || bus3.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stall got=%b/%b exp=0/0", bus1.stall, bus3.stall);
        end
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        step();
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NS; i++) id_rs[i*AW +: AW] = AW'($urandom_range(0, 3));
            id_rs_used = NS'($urandom);
            ex_rd = AW'($urandom_range(0, 3));
            ex_regwrite = $urandom_range(0, 1) == 1;
            ex_memread = $urandom_range(0, 3) == 0;
            ex_mem_rd = AW'($urandom_range(0, 3));
            ex_mem_regwrite = $urandom_range(0, 1) == 1;
            ex_mem_data = DW'($urandom);
            mem_wb_rd = AW'($urandom_range(0, 3));
            mem_wb_regwrite = $urandom_range(0, 1) == 1;
            mem_wb_data = DW'($urandom);
            ex_rf_data = RFW'($urandom);
            step();
        end
        clear_inputs();
        flush = 1;
        step();
        flush = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_dep();
        test_stale_rf();
        test_load_use_lat1();
        test_stall_len_lat3();
        test_flush_lat3();
        test_x0_unused();
        test_priority();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
